// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM encoding, byte-enable constants and alignment helper
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;

   localparam int WAIT_CNT_W = 4;

   // An empty byte mask touches nothing, so it is never treated as misaligned.
   function automatic logic be_aligned(input logic [1:0] off, input logic [3:0] be);
      return (be == 4'b0000) ||
             (be == BE_WORD && off == 2'd0) ||
             (be == BE_HALF_LO && off == 2'd0) ||
             (be == BE_HALF_HI && off == 2'd2) ||
             (be == (4'b0001 << off));
   endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port DEPTHx32 storage, synchronous read, per-byte write enables, no reset
module sram_1rw_be #(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // One access per enabled cycle: byte-masked write or registered read.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++)
               if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end else begin
            rdata_o <= mem_q[addr_i];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: DMEM slave with wait states and response channel; optional DMEM_MISALIGN_CHECK_EN
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [3:0]  req_be_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int AW = $clog2(DEPTH);

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]         idx_q;
   logic                  we_q;
   logic [3:0]            be_q;
   logic [31:0]           wdata_q;
   logic                  err_q;
   logic                  resp_valid_q;
   logic                  resp_err_q;
   logic [31:0]           resp_rdata_q;
   logic                  accept;
   logic                  out_of_range;
   logic                  misalign;
   logic [31:0]           mem_rdata;

   assign accept       = (state_q == ST_IDLE) && req_valid_i;
   assign out_of_range = {2'b00, req_addr_i[31:2]} >= 32'(DEPTH);

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = req_we_i ? !be_aligned(req_addr_i[1:0], req_be_i) : (req_addr_i[1:0] != 2'b00);
`else
   logic unused_offset;
   assign unused_offset = ^req_addr_i[1:0];
   assign misalign      = 1'b0;
`endif

   // Next-state and wait counter; counter only matters while in WAIT.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
               cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
            end
         end
         ST_WAIT: begin
            cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? ST_ACCESS : ST_WAIT;
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = (resp_valid_q && resp_ready_i) ? ST_IDLE : ST_RESP;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State, counter and the request latched at acceptance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            idx_q   <= req_addr_i[AW+1:2];
            we_q    <= req_we_i;
            be_q    <= req_be_i;
            wdata_q <= req_wdata_i;
            err_q   <= out_of_range || misalign;
         end
      end
   end

   // Errored accesses never reach the array, so no write and no read happens.
   sram_1rw_be #(.DEPTH(DEPTH)) u_sram (
      .clk_i   (clk_i),
      .en_i    ((state_q == ST_ACCESS) && !err_q),
      .we_i    (we_q),
      .be_i    (be_q),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   // Capture the array's read result one cycle after ACCESS and hold it until handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else if (state_q == ST_RESP && !resp_valid_q) begin
         resp_valid_q <= 1'b1;
         resp_rdata_q <= (we_q || err_q) ? '0 : mem_rdata;
         resp_err_q   <= err_q;
      end else if (resp_valid_q && resp_ready_i) begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder at WAIT_CYCLES 0, 3 and 4
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  vld = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic        rr = 1'b0;
   logic        rdy [3];
   logic        rv  [3];
   logic        er  [3];
   logic [31:0] rd  [3];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
      .req_addr_i(addr), .req_we_i(we), .req_be_i(be), .req_wdata_i(wdata),
      .resp_valid_o(rv[0]), .resp_ready_i(rr), .resp_rdata_o(rd[0]), .resp_err_o(er[0]));

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
      .req_addr_i(addr), .req_we_i(we), .req_be_i(be), .req_wdata_i(wdata),
      .resp_valid_o(rv[1]), .resp_ready_i(rr), .resp_rdata_o(rd[1]), .resp_err_o(er[1]));

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld[2]), .req_ready_o(rdy[2]),
      .req_addr_i(addr), .req_we_i(we), .req_be_i(be), .req_wdata_i(wdata),
      .resp_valid_o(rv[2]), .resp_ready_i(rr), .resp_rdata_o(rd[2]), .resp_err_o(er[2]));

   task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input int hold, output int lat,
                      output logic [31:0] data, output logic e, output logic busy_rdy,
                      output logic unstable);
      int n;
      n = 0;
      while (!rdy[d] && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!rdy[d]) begin
         checks++; failures++;
         $display("FAIL accept_timeout dut%0d ready=%b required=1", d, rdy[d]);
      end
      vld[d] = 1'b1; we = w; addr = a; be = b; wdata = wd;
      @(posedge clk); #1;
      vld[d] = 1'b0;
      lat = 0;
      busy_rdy = rdy[d];
      while (!rv[d] && lat < 50) begin
         @(posedge clk); #1; lat++;
         busy_rdy |= rdy[d];
      end
      if (!rv[d]) begin
         checks++; failures++;
         $display("FAIL resp_timeout dut%0d valid=%b required=1", d, rv[d]);
      end
      data = rd[d];
      e = er[d];
      unstable = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         if (rv[d] !== 1'b1 || rd[d] !== data || er[d] !== e || rdy[d] !== 1'b0) unstable = 1'b1;
      end
      rr = 1'b1;
      @(posedge clk); #1;
      rr = 1'b0;
      checks++;
      if (rv[d] !== 1'b0 || rdy[d] !== 1'b1) begin
         failures++;
         $display("FAIL release dut%0d valid=%b ready=%b required valid=0 ready=1", d, rv[d], rdy[d]);
      end
   endtask

   task automatic test_reset();
      #12;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rdy[i] !== 1'b1) begin failures++; $display("FAIL reset_ready dut%0d got=%b exp=1", i, rdy[i]); end
         checks++;
         if (rv[i] !== 1'b0) begin failures++; $display("FAIL reset_valid dut%0d got=%b exp=0", i, rv[i]); end
         checks++;
         if (rd[i] !== 32'h0) begin failures++; $display("FAIL reset_rdata dut%0d got=%h exp=0", i, rd[i]); end
         checks++;
         if (er[i] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b exp=0", i, er[i]); end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] d; logic e, br, us;
      txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, lat, d, e, br, us);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL store_latency got=%0d exp=2", lat); end
      checks++;
      if (d !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL store_resp rdata=%h err=%b exp rdata=0 err=0", d, e); end
      txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL load_latency got=%0d exp=2", lat); end
      checks++;
      if (d !== 32'hDEADBEEF || e !== 1'b0) begin failures++; $display("FAIL load_data rdata=%h err=%b exp rdata=deadbeef err=0", d, e); end
   endtask

   task automatic test_byte_mask();
      int lat; logic [31:0] d; logic e, br, us;
      txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 0, lat, d, e, br, us);
      txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, lat, d, e, br, us);
      txn(0, 1'b0, 32'h20, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (d !== 32'h11BB33DD) begin failures++; $display("FAIL byte_mask got=%h exp=11bb33dd", d); end
      txn(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 0, lat, d, e, br, us);
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL be_zero_err got=%b exp=0", e); end
      txn(0, 1'b0, 32'h20, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (d !== 32'h11BB33DD) begin failures++; $display("FAIL be_zero_data got=%h exp=11bb33dd", d); end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] d; logic e, br, us;
      txn(1, 1'b0, 32'h1000, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL oor_load err=%b rdata=%h exp err=1 rdata=0", e, d); end
      checks++;
      if (lat != 5) begin failures++; $display("FAIL oor_latency got=%0d exp=5", lat); end
      checks++;
      if (br !== 1'b0) begin failures++; $display("FAIL oor_ready_busy got=%b exp=0", br); end
      txn(1, 1'b1, 32'h0, 4'hF, 32'h12345678, 0, lat, d, e, br, us);
      txn(1, 1'b1, 32'hFFC, 4'hF, 32'h0BADF00D, 0, lat, d, e, br, us);
      txn(1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 0, lat, d, e, br, us);
      checks++;
      if (e !== 1'b1) begin failures++; $display("FAIL oor_store_err got=%b exp=1", e); end
      txn(1, 1'b0, 32'h0, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (d !== 32'h12345678) begin failures++; $display("FAIL oor_no_write got=%h exp=12345678", d); end
      txn(1, 1'b0, 32'hFFC, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (d !== 32'h0BADF00D || e !== 1'b0) begin failures++; $display("FAIL last_word rdata=%h err=%b exp rdata=0badf00d err=0", d, e); end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] d; logic e, br, us;
      txn(1, 1'b0, 32'hFFC, 4'h0, 32'h0, 6, lat, d, e, br, us);
      checks++;
      if (us !== 1'b0) begin failures++; $display("FAIL backpressure_stable got=%b exp=0", us); end
      checks++;
      if (d !== 32'h0BADF00D) begin failures++; $display("FAIL backpressure_data got=%h exp=0badf00d", d); end
   endtask

   task automatic test_idle_resp_ready();
      logic seen;
      seen = 1'b0;
      rr = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         seen |= rv[0] | rv[1] | rv[2];
      end
      rr = 1'b0;
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL idle_resp_ready valid_seen=%b exp=0", seen); end
   endtask

   task automatic test_reset_mid_wait();
      int lat; logic [31:0] d; logic e, br, us;
      txn(2, 1'b1, 32'h40, 4'hF, 32'h01020304, 0, lat, d, e, br, us);
      vld[2] = 1'b1; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'h55AA55AA;
      @(posedge clk); #1;
      vld[2] = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rdy[2] !== 1'b1 || rv[2] !== 1'b0 || rd[2] !== 32'h0 || er[2] !== 1'b0) begin
         failures++;
         $display("FAIL async_reset ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0", rdy[2], rv[2], rd[2], er[2]);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(2, 1'b0, 32'h40, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (d !== 32'h01020304) begin failures++; $display("FAIL dropped_store got=%h exp=01020304", d); end
   endtask

   task automatic test_misalign();
      int lat; logic [31:0] d; logic e, br, us;
      txn(0, 1'b1, 32'h40, 4'hF, 32'h01020304, 0, lat, d, e, br, us);
`ifdef DMEM_MISALIGN_CHECK_EN
      txn(0, 1'b0, 32'h42, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL misalign_load err=%b rdata=%h exp err=1 rdata=0", e, d); end
      txn(0, 1'b1, 32'h42, 4'b1100, 32'hCAFE0000, 0, lat, d, e, br, us);
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL aligned_half_store err=%b exp=0", e); end
      txn(0, 1'b0, 32'h40, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (d !== 32'hCAFE0304) begin failures++; $display("FAIL half_store_data got=%h exp=cafe0304", d); end
`else
      txn(0, 1'b0, 32'h42, 4'h0, 32'h0, 0, lat, d, e, br, us);
      checks++;
      if (d !== 32'h01020304 || e !== 1'b0) begin failures++; $display("FAIL offset_ignored rdata=%h err=%b exp rdata=01020304 err=0", d, e); end
`endif
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_mask();
      test_out_of_range();
      test_backpressure();
      test_idle_resp_ready();
      test_reset_mid_wait();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
